// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: orders DMEM wait > load-use > branch > IMEM wait.
// Latency: control outputs are combinational from state + inputs; state advances on clk.
// Backpressure: holds the front end on memory waits; optional HAZARD_STATS_EN adds stall counters.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT_W = 8,
    parameter int MEM_TIMEOUT   = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ex_hazard,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        imem_ready,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_stall,
    output logic        idex_flush,
    output logic        exmem_stall,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        bus_error,
    output logic [2:0]  ctrl_state,
    output logic [31:0] lu_cnt,
    output logic [31:0] br_cnt,
    output logic [31:0] dw_cnt
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        LU_STALL  = 3'd1,
        DMEM_WAIT = 3'd2,
        IMEM_WAIT = 3'd3,
        ERR       = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [MEM_TIMEOUT_W-1:0] wait_cnt_q;
    logic                     bus_error_q;
    logic                     dmem_wait;
    logic                     dw_ev;
    logic                     timeout_hit;

    assign dmem_wait   = dmem_req & ~dmem_ready;
    assign timeout_hit = (wait_cnt_q == MEM_TIMEOUT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (dw_ev)
                wait_cnt_q <= wait_cnt_q + MEM_TIMEOUT_W'(1);
            else
                wait_cnt_q <= '0;
            if (dw_ev && timeout_hit)
                bus_error_q <= 1'b1;
        end
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        dw_ev       = 1'b0;
        state_d     = state_q;
        if (!rst_n) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            state_d     = RUN;
        end else if (state_q == ERR) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (dmem_wait) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
            dw_ev       = 1'b1;
            state_d     = timeout_hit ? ERR : DMEM_WAIT;
        end else if (state_q == RUN && mem_ex_hazard) begin
            // Any coincident branch is dropped; it re-resolves once the load clears.
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = LU_STALL;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
        end else if (!imem_ready) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
            state_d    = IMEM_WAIT;
        end else begin
            state_d = RUN;
        end
    end

    assign bus_error  = bus_error_q;
    assign ctrl_state = state_q;

`ifdef HAZARD_STATS_EN
    logic lu_ev, br_ev;
    logic [31:0] lu_cnt_q, br_cnt_q, dw_cnt_q;

    // Outside reset, exmem_flush only comes from load-use and idex_flush only from a branch.
    assign lu_ev = rst_n & exmem_flush;
    assign br_ev = rst_n & idex_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_cnt_q <= '0;
            br_cnt_q <= '0;
            dw_cnt_q <= '0;
        end else begin
            if (lu_ev && lu_cnt_q != '1) lu_cnt_q <= lu_cnt_q + 32'd1;
            if (br_ev && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
            if (dw_ev && dw_cnt_q != '1) dw_cnt_q <= dw_cnt_q + 32'd1;
        end
    end

    assign lu_cnt = lu_cnt_q;
    assign br_cnt = br_cnt_q;
    assign dw_cnt = dw_cnt_q;
`else
    assign lu_cnt = '0;
    assign br_cnt = '0;
    assign dw_cnt = '0;
`endif

endmodule
